// File: rtl/sync_link_pkg.sv
// ============================================================================
//  Module      : sync_link_pkg
//  Description : Shared definitions for the sync-word serial link
//                (transmitter and Mealy sync detector). Holds the frame
//                FSM state encoding, the default sync pattern and the
//                minimum trailing gap length.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_link_pkg;

  // Frame FSM states, shared with the detector side for waveform/debug
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_SYNC = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam int         DEFAULT_SYNC_W    = 4;
  localparam logic [3:0] DEFAULT_SYNC_WORD = 4'b1101;

  // Two low bits drain a trailing 11 / 110 out of the far-end detector
  localparam int         MIN_GAP_BITS      = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_word_tx_piso_shift.sv
// ============================================================================
//  Module      : piso_shift
//  Description : DATA_W-bit parallel-load, shift-left-on-enable register.
//                MSB is presented on o_msb; zeros fill from the LSB end.
//                Load has priority over shift.
//  Ports       : clk, rst (async, active-high)
//                i_load  - capture i_data
//                i_data  - parallel word
//                i_shift - shift left by one
//                o_msb   - current MSB
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
    end
  end

  assign o_msb = r_sr[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/sync_word_tx.sv
// ============================================================================
//  Module      : sync_word_tx
//  Description : Serial frame transmitter. Each frame is the sync word
//                (MSB first), the DATA_W-bit payload (MSB first) and
//                GAP_BITS low bits. Words arrive on a valid/ready
//                handshake; bit_en sets the bit rate.
//  Ports       : clk, rst (async, active-high)
//                bit_en     - one-clk bit-period strobe
//                tx_valid   - tx_data valid
//                tx_data    - payload word
//                tx_ready   - word can be accepted (IDLE only)
//                outp       - registered serial line
//                busy       - frame in progress
//                frame_done - pulse during the clk that ends the last gap bit
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_word_tx
  import sync_link_pkg::*;
#(
  parameter int                SYNC_W    = DEFAULT_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD),
  parameter int                DATA_W    = 8,
  parameter int                GAP_BITS  = MIN_GAP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              outp,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP_BITS);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] C_SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_BITS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_outp;
  logic              w_outp_nxt;
  logic              w_accept;
  logic              w_load;
  logic              w_shift;
  logic              w_msb;
  logic              w_frame_done;
  logic [SYNC_W-1:0] w_sync_sh;

  assign tx_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign outp       = r_outp;
  assign frame_done = w_frame_done;
  assign w_accept   = tx_valid && tx_ready;

  // r_cnt bits of the sync word have been sent (plus the one on the line),
  // so the next sync bit is the MSB after shifting out r_cnt+1 bits.
  assign w_sync_sh  = SYNC_WORD << (r_cnt + C_CNT_ONE);

  piso_shift #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (tx_data),
    .i_shift (w_shift),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_outp  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_outp  <= w_outp_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_outp_nxt   = r_outp;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_frame_done = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // bit_en is ignored here: a strobe coinciding with accept only accepts
        w_outp_nxt = 1'b0;
        if (w_accept) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_outp_nxt = 1'b0;
        if (bit_en) begin
          w_outp_nxt  = SYNC_WORD[SYNC_W-1];
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (bit_en) begin
          if (r_cnt == C_SYNC_LAST) begin
            // Put payload MSB on the line and pre-shift so o_msb is the next bit
            w_outp_nxt  = w_msb;
            w_shift     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DATA;
          end else begin
            w_outp_nxt = w_sync_sh[SYNC_W-1];
            w_cnt_nxt  = r_cnt + C_CNT_ONE;
          end
        end
      end

      ST_DATA: begin
        if (bit_en) begin
          if (r_cnt == C_DATA_LAST) begin
            w_outp_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_outp_nxt = w_msb;
            w_shift    = 1'b1;
            w_cnt_nxt  = r_cnt + C_CNT_ONE;
          end
        end
      end

      ST_GAP: begin
        w_outp_nxt = 1'b0;
        if (bit_en) begin
          if (r_cnt == C_GAP_LAST) begin
            w_frame_done = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
      end

      default: begin
        w_outp_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_word_tx.sv
// ============================================================================
//  Module      : tb_sync_word_tx
//  Description : Directed self-checking bench for sync_word_tx
//                (SYNC_W=4, SYNC_WORD=1101, DATA_W=8, GAP_BITS=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_word_tx;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       outp;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  sync_word_tx dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .outp       (outp),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a word (bit_en left as the caller set it) and confirm it lands in WAIT
  task automatic send(input logic [7:0] d, input string tag);
    tx_data  = d;
    tx_valid = 1'b1;
    #1;
    check({tag, "_ready_before"}, {31'd0, tx_ready}, 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check({tag, "_busy_wait"},  {31'd0, busy},     32'd1);
    check({tag, "_ready_wait"}, {31'd0, tx_ready}, 32'd0);
    check({tag, "_outp_wait"},  {31'd0, outp},     32'd0);
  endtask

  // Step one frame from WAIT: 15 bit_en strobes, each followed by period-1
  // idle clks. After strobe j (j<14) the line carries frame bit j.
  // pulse_j >= 0 offers a competing word during that strobe.
  task automatic run_frame(input logic [13:0] exp_bits, input int period,
                           input int pulse_j, input string tag);
    logic exp_b;
    for (int j = 0; j <= 14; j++) begin
      bit_en = 1'b1;
      if (j == pulse_j) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
      end
      #1;
      check($sformatf("%s_fdone_%0d", tag, j), {31'd0, frame_done},
            (j == 14) ? 32'd1 : 32'd0);
      if (j == pulse_j)
        check({tag, "_ready_busy"}, {31'd0, tx_ready}, 32'd0);
      @(posedge clk); #1;
      tx_valid = (j == pulse_j) ? 1'b0 : tx_valid;
      bit_en   = (period == 1);
      exp_b    = (j < 14) ? exp_bits[13-j] : 1'b0;
      check($sformatf("%s_bit_%0d", tag, j), {31'd0, outp}, {31'd0, exp_b});
      for (int k = 1; k < period; k++) begin
        @(posedge clk); #1;
        check($sformatf("%s_hold_%0d_%0d", tag, j, k), {31'd0, outp}, {31'd0, exp_b});
      end
    end
    check({tag, "_busy_end"},  {31'd0, busy},     32'd0);
    check({tag, "_ready_end"}, {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    bit_en   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outp",  {31'd0, outp},       32'd0);
    check("rst_ready", {31'd0, tx_ready},   32'd1);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_fdone", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // Idle line with bit_en running and no valid: nothing starts
    bit_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_outp", {31'd0, outp}, 32'd0);

    // A5 at one bit per clk; bit_en high during accept must not skip WAIT
    send(8'hA5, "a5");
    run_frame(14'b1101_10100101_00, 1, -1, "a5");

    // 3C with bit_en every 4th clk
    bit_en = 1'b0;
    @(posedge clk); #1;
    send(8'h3C, "3c");
    run_frame(14'b1101_00111100_00, 4, -1, "3c");

    // Back-to-back FF then 00 with tx_valid held throughout
    bit_en   = 1'b1;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_acc1_busy", {31'd0, busy}, 32'd1);
    tx_data = 8'h00;
    run_frame(14'b1101_11111111_00, 1, -1, "ff");
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("b2b_acc2_busy",  {31'd0, busy},     32'd1);
    check("b2b_acc2_ready", {31'd0, tx_ready}, 32'd0);
    run_frame(14'b1101_00000000_00, 1, -1, "00");

    // Competing word offered mid-payload is ignored
    send(8'h96, "96");
    run_frame(14'b1101_10010110_00, 1, 7, "96");
    @(posedge clk); #1;
    check("96_no_reaccept", {31'd0, busy}, 32'd0);

    // Async reset during payload bit 3, then a clean frame
    send(8'h5A, "5a");
    repeat (8) @(posedge clk);
    #1;
    check("5a_pre_rst_outp", {31'd0, outp}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outp",  {31'd0, outp},     32'd0);
    check("async_rst_ready", {31'd0, tx_ready}, 32'd1);
    check("async_rst_busy",  {31'd0, busy},     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_outp", {31'd0, outp}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    send(8'h81, "81");
    run_frame(14'b1101_10000001_00, 1, -1, "81");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
